// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential divider.
package seq_div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract the divisor.
module seq_div_step
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;

  // Shifted remainder keeps the bit leaving rem, so large divisors compare correctly.
  always_comb begin
    shifted_s = {rem, quo[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, divisor};
    if (!trial_s[WIDTH]) begin
      rem_next = trial_s[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted_s[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider producing {remainder, quotient}, one bit per cycle.
// Signed division is available when SEQ_DIVIDER_SIGNED_EN is defined.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] dataOut
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e         state_r;
  div_state_e         state_s;
  logic               load_s;
  logic               finish_s;
  logic               zero_load_s;

  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   quo_r;
  logic [WIDTH-1:0]   divisor_r;
  logic [CW-1:0]      count_r;
  logic [WIDTH-1:0]   rem_step_s;
  logic [WIDTH-1:0]   quo_step_s;

  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH-1:0]   res_rem_s;
  logic [WIDTH-1:0]   res_quo_s;

  logic               busy_r;
  logic               done_r;
  logic               dbz_r;
  logic [2*WIDTH-1:0] data_out_r;

  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (divisor_r),
    .rem_next (rem_step_s),
    .quo_next (quo_step_s)
  );

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_quo_r;
  logic neg_rem_r;

  // Signed operands are divided as magnitudes; signs are reapplied to the result.
  always_comb begin
    a_mag_s = dataA;
    b_mag_s = dataB;
    if (is_signed && dataA[WIDTH-1]) begin
      a_mag_s = {WIDTH{1'b0}} - dataA;
    end else begin
      a_mag_s = dataA;
    end
    if (is_signed && dataB[WIDTH-1]) begin
      b_mag_s = {WIDTH{1'b0}} - dataB;
    end else begin
      b_mag_s = dataB;
    end
  end

  // Sign fix-up of the final step's result.
  always_comb begin
    res_quo_s = quo_step_s;
    res_rem_s = rem_step_s;
    if (neg_quo_r) begin
      res_quo_s = {WIDTH{1'b0}} - quo_step_s;
    end else begin
      res_quo_s = quo_step_s;
    end
    if (neg_rem_r) begin
      res_rem_s = {WIDTH{1'b0}} - rem_step_s;
    end else begin
      res_rem_s = rem_step_s;
    end
  end

  // Result signs captured with the operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
    end else if (load_s) begin
      neg_quo_r <= is_signed & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
      neg_rem_r <= is_signed & dataA[WIDTH-1];
    end
  end
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;

  // Unsigned-only build: operands and result pass straight through.
  always_comb begin
    a_mag_s   = dataA;
    b_mag_s   = dataB;
    res_quo_s = quo_step_s;
    res_rem_s = rem_step_s;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_s     = state_r;
    load_s      = 1'b0;
    finish_s    = 1'b0;
    zero_load_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && (dataB == {WIDTH{1'b0}})) begin
          state_s     = DONE;
          zero_load_s = 1'b1;
        end else if (start) begin
          state_s = DIV;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      DIV: begin
        if (count_r == {CW{1'b0}}) begin
          state_s  = DONE;
          finish_s = 1'b1;
        end else begin
          state_s = DIV;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand registers, step iteration and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_r      <= {WIDTH{1'b0}};
      quo_r      <= {WIDTH{1'b0}};
      divisor_r  <= {WIDTH{1'b0}};
      count_r    <= {CW{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      dbz_r      <= 1'b0;
      data_out_r <= {(2*WIDTH){1'b0}};
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= finish_s | zero_load_s;
      if (load_s) begin
        rem_r     <= {WIDTH{1'b0}};
        quo_r     <= a_mag_s;
        divisor_r <= b_mag_s;
        count_r   <= CW'(WIDTH - 1);
      end else if (state_r == DIV) begin
        rem_r   <= rem_step_s;
        quo_r   <= quo_step_s;
        count_r <= count_r - CW'(1);
      end
      if (finish_s) begin
        data_out_r <= {res_rem_s, res_quo_s};
        dbz_r      <= 1'b0;
      end else if (zero_load_s) begin
        data_out_r <= {dataA, {WIDTH{1'b1}}};
        dbz_r      <= 1'b1;
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign dataOut     = data_out_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32) against a plain-arithmetic reference model.
module tb_seq_divider;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif
  localparam int N_RANDOM = 1500;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [63:0] dataOut;

  int n_cmp;
  int n_err;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dataA       (dataA),
    .dataB       (dataB),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .dataOut     (dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {remainder, quotient} from language division operators.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint la, lb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      q  = la / lb;
      r  = la % lb;
    end else begin
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
      q  = la / lb;
      r  = la % lb;
    end
    qv = 64'(q);
    rv = 64'(r);
    return {rv[31:0], qv[31:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] b);
    return (b == 32'd0) ? 1 : 33;
  endfunction

  // Issue one operation, scramble the inputs while it runs, wait (bounded) for done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output logic [63:0] res, output logic dbz, output int lat);
    @(negedge clk);
    start = 1'b1; dataA = a; dataB = b; is_signed = sgn;
    @(negedge clk);
    start = 1'b0; dataA = $urandom; dataB = $urandom; is_signed = ~sgn;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = dataOut;
    dbz = div_by_zero;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; dataA = 32'd100; dataB = 32'd7; is_signed = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    n_cmp++; if (dataOut !== 64'd0) begin n_err++; $display("FAIL reset_dataOut got=%h exp=0", dataOut); end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_idle got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    logic [63:0] res; logic dbz; int lat;
    run_op(32'd100, 32'd7, 1'b0, res, dbz, lat);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL basic_latency got=%0d exp=33", lat); end
    n_cmp++; if (res !== {32'd2, 32'd14}) begin n_err++; $display("FAIL basic_result got=%h exp=%h", res, {32'd2, 32'd14}); end
    n_cmp++; if (dbz !== 1'b0) begin n_err++; $display("FAIL basic_dbz got=%b exp=0", dbz); end
    repeat (4) @(negedge clk);
    n_cmp++; if (dataOut !== {32'd2, 32'd14}) begin n_err++; $display("FAIL basic_hold got=%h exp=%h", dataOut, {32'd2, 32'd14}); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_idle got=%b exp=0", done); end
  endtask

  task automatic test_div_by_zero();
    logic [63:0] res; logic dbz; int lat;
    run_op(32'h1234_5678, 32'd0, 1'b0, res, dbz, lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
    n_cmp++; if (res !== {32'h1234_5678, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL dbz_result got=%h exp=%h", res, {32'h1234_5678, 32'hFFFF_FFFF}); end
    n_cmp++; if (dbz !== 1'b1) begin n_err++; $display("FAIL dbz_flag got=%b exp=1", dbz); end
    repeat (3) @(negedge clk);
    n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz_hold got=%b exp=1", div_by_zero); end
  endtask

  task automatic test_boundaries();
    logic [63:0] res; logic dbz; int lat;
    run_op(32'd5, 32'd9, 1'b0, res, dbz, lat);
    n_cmp++; if (res !== {32'd5, 32'd0}) begin n_err++; $display("FAIL small_dividend got=%h exp=%h", res, {32'd5, 32'd0}); end
    n_cmp++; if (dbz !== 1'b0) begin n_err++; $display("FAIL dbz_cleared got=%b exp=0", dbz); end
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, res, dbz, lat);
    n_cmp++; if (res !== {32'd0, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL max_by_one got=%h exp=%h", res, {32'd0, 32'hFFFF_FFFF}); end
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL max_by_one_latency got=%0d exp=33", lat); end
    run_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, res, dbz, lat);
    n_cmp++; if (res !== ref_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0)) begin
      n_err++; $display("FAIL large_divisor got=%h exp=%h", res, ref_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0));
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    start = 1'b1; dataA = 32'd1000; dataB = 32'd3; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 10) begin
        start = 1'b1; dataA = 32'd77; dataB = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL restart_latency got=%0d exp=33", lat); end
    n_cmp++; if (dataOut !== {32'd1, 32'd333}) begin n_err++; $display("FAIL restart_result got=%h exp=%h", dataOut, {32'd1, 32'd333}); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL restart_dbz got=%b exp=0", div_by_zero); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL restart_second_op got_busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_abort();
    logic [63:0] res; logic dbz; int lat; logic seen_done;
    seen_done = 1'b0;
    @(negedge clk);
    start = 1'b1; dataA = 32'd999; dataB = 32'd10; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      if (done === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", busy); end
    n_cmp++; if (dataOut !== 64'd0) begin n_err++; $display("FAIL abort_dataOut got=%h exp=0", dataOut); end
    reset = 1'b0;
    repeat (40) begin
      if (done === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (seen_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done got=%b exp=0", seen_done); end
    run_op(32'd999, 32'd10, 1'b0, res, dbz, lat);
    n_cmp++; if (res !== {32'd9, 32'd99}) begin n_err++; $display("FAIL after_abort_result got=%h exp=%h", res, {32'd9, 32'd99}); end
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL after_abort_latency got=%0d exp=33", lat); end
  endtask

  task automatic test_signed();
    logic [63:0] res; logic dbz; int lat;
    logic [31:0] a_tab [4];
    logic [31:0] b_tab [4];
    logic [63:0] e_tab [4];
    a_tab[0] = 32'hFFFF_FFF9; b_tab[0] = 32'd2;          e_tab[0] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    a_tab[1] = 32'd7;         b_tab[1] = 32'hFFFF_FFFE;  e_tab[1] = {32'd1, 32'hFFFF_FFFD};
    a_tab[2] = 32'h8000_0000; b_tab[2] = 32'hFFFF_FFFF;  e_tab[2] = {32'd0, 32'h8000_0000};
    a_tab[3] = 32'hFFFF_FFF9; b_tab[3] = 32'hFFFF_FFFE;  e_tab[3] = {32'hFFFF_FFFF, 32'd3};
    for (int i = 0; i < 4; i++) begin
      if (!SIGNED_BUILD) e_tab[i] = {a_tab[i] % b_tab[i], a_tab[i] / b_tab[i]};
      run_op(a_tab[i], b_tab[i], 1'b1, res, dbz, lat);
      n_cmp++; if (res !== e_tab[i]) begin n_err++; $display("FAIL signed_%0d got=%h exp=%h", i, res, e_tab[i]); end
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL signed_latency_%0d got=%0d exp=33", i, lat); end
    end
  endtask

  task automatic test_random();
    logic [63:0] res, exp_res; logic dbz; int lat;
    logic [31:0] a, b; logic sgn;
    for (int i = 0; i < N_RANDOM; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 255);
        2:       b = $urandom >> $urandom_range(0, 31);
        3:       b = a >> $urandom_range(0, 8);
        default: b = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
      endcase
      sgn = 1'($urandom_range(0, 1));
      exp_res = ref_div(a, b, sgn & SIGNED_BUILD);
      run_op(a, b, sgn, res, dbz, lat);
      n_cmp++; if (res !== exp_res) begin n_err++; $display("FAIL rand_result a=%h b=%h s=%b got=%h exp=%h", a, b, sgn, res, exp_res); end
      n_cmp++; if (dbz !== (b == 32'd0)) begin n_err++; $display("FAIL rand_dbz b=%h got=%b exp=%b", b, dbz, (b == 32'd0)); end
      n_cmp++; if (lat !== ref_lat(b)) begin n_err++; $display("FAIL rand_latency b=%h got=%0d exp=%0d", b, lat, ref_lat(b)); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rand_done_width got=%b exp=0", done); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rand_busy_fall got=%b exp=0", busy); end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dataA = 32'd0; dataB = 32'd0;
    test_reset();
    test_basic();
    test_div_by_zero();
    test_boundaries();
    test_start_ignored();
    test_reset_abort();
    test_signed();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
